// File: rtl/seq1011_framer_tx.sv
// -----------------------------------------------------------------------------
// seq1011_framer_tx
//
// Purpose
//   Serial frame transmitter for the 1011 sync-word link. One bit is driven on
//   the line per clock cycle. A frame on the line is:
//
//     preamble 1011 | DATA_W payload bits, MSB first | even parity | GAP zeros
//
//   Payload and parity bits are bit-stuffed: whenever the last three bits on
//   the line read 101 after a payload or parity bit, a single 0 is inserted.
//   Because of this the pattern 1011 only ever appears at the preamble, so a
//   1011 detector at the far end fires exactly once per frame, on the last
//   preamble bit. The receiver drops the bit that follows every 101 seen in
//   the payload region.
//
//   Frame length = 4 + DATA_W + nstuff + 1 + GAP cycles.
//
// Parameters
//   DATA_W  payload width in bits (>= 1)
//   GAP     idle-0 bits after parity, before the next frame (>= 3)
//
// Ports
//   clk     in   1       rising-edge clock
//   reset   in   1       synchronous, active-high; clears all state
//   start   in   1       frame request; taken only when the framer can accept
//   din     in   DATA_W  payload; captured at the accept edge
//   ready   out  1       1 = idle, a start will be accepted
//   tx      out  1       serial line (registered), idles 0
//   active  out  1       1 while preamble, payload, stuff or parity is on tx
//   done    out  1       1-cycle pulse during the last GAP bit
// -----------------------------------------------------------------------------
module seq1011_framer_tx #(
  parameter int DATA_W = 8,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              tx,
  output logic              active,
  output logic              done
);

  // Bit index counts payload bits already placed on the line (0..DATA_W).
  localparam int IW = $clog2(DATA_W + 1);
  // Gap counter indexes the gap bit currently on the line (0..GAP-1).
  localparam int GW = $clog2(GAP + 1);

  localparam logic [IW-1:0] IDX_FULL = IW'(DATA_W);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  // Each state names the kind of bit currently shown on tx.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_STUFF,
    S_PAR,
    S_GAP
  } state_t;

  state_t            r_state;
  logic              r_tx;
  logic              r_ready;
  logic              r_active;
  logic              r_done;
  logic [DATA_W-1:0] r_shreg;    // remaining payload, next bit at MSB
  logic              r_par;      // XOR of payload bits sent so far
  logic [IW-1:0]     r_idx;      // payload bits already sent
  logic [1:0]        r_pre_cnt;  // preamble bit currently on tx
  logic [2:0]        r_pre_sh;   // preamble bits still to send, next at MSB
  logic [GW-1:0]     r_gap_cnt;  // gap bit currently on tx
  logic [2:0]        r_hist;     // last three bits driven on tx, newest at LSB

  logic              w_accept;
  logic              w_more_data;
  logic              w_payload_bit;
  logic              w_stuff;
  logic              w_payload_step;
  logic [GW-1:0]     w_gap_inc;

  // A start is taken when idle, and also at the edge that closes the last gap
  // bit (done=1). Taking it there lets a held start produce frames separated
  // by exactly GAP zeros, with no extra idle bit in between.
  assign w_accept = start & (r_ready | r_done);

  // After the preamble every non-stuff bit is either the next payload bit or,
  // once the payload is exhausted, the parity bit.
  assign w_more_data   = (r_idx != IDX_FULL);
  assign w_payload_bit = w_more_data ? r_shreg[DATA_W-1] : r_par;

  // A stuff 0 is due when the payload/parity bit just sent completed 101.
  // Only DATA can trigger it here: after a stuff the history ends in 0, and a
  // stuff owed after parity is covered by the first gap zero.
  assign w_stuff = (r_state == S_DATA) && (r_hist == 3'b101);

  // Last preamble bit, any payload bit, and a stuff bit are all followed by
  // the next payload or parity bit (unless a stuff is due first).
  assign w_payload_step = ((r_state == S_PRE) && (r_pre_cnt == 2'd3)) ||
                          (r_state == S_DATA) || (r_state == S_STUFF);

  assign w_gap_inc = r_gap_cnt + GW'(1);

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; mixing in = here would make the result depend on
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b0;
      r_ready   <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_idx     <= '0;
      r_pre_cnt <= '0;
      r_pre_sh  <= '0;
      r_gap_cnt <= '0;
      r_hist    <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        // First preamble bit goes out right away; the rest follow from r_pre_sh.
        r_state   <= S_PRE;
        r_tx      <= 1'b1;
        r_pre_cnt <= 2'd0;
        r_pre_sh  <= 3'b011;
        r_hist    <= 3'b001;
        r_shreg   <= din;
        r_par     <= 1'b0;
        r_idx     <= '0;
        r_ready   <= 1'b0;
        r_active  <= 1'b1;
      end else if (w_stuff) begin
        r_state <= S_STUFF;
        r_tx    <= 1'b0;
        r_hist  <= {r_hist[1:0], 1'b0};
      end else if (w_payload_step) begin
        r_tx   <= w_payload_bit;
        r_hist <= {r_hist[1:0], w_payload_bit};
        if (w_more_data) begin
          r_state <= S_DATA;
          r_shreg <= r_shreg << 1;
          r_par   <= r_par ^ w_payload_bit;
          r_idx   <= r_idx + IW'(1);
        end else begin
          r_state <= S_PAR;
        end
      end else begin
        unique case (r_state)
          S_PRE: begin
            // The preamble also feeds the history, so it reads 011 once the
            // preamble is complete.
            r_tx      <= r_pre_sh[2];
            r_hist    <= {r_hist[1:0], r_pre_sh[2]};
            r_pre_sh  <= {r_pre_sh[1:0], 1'b0};
            r_pre_cnt <= r_pre_cnt + 2'd1;
          end
          S_PAR: begin
            r_state   <= S_GAP;
            r_tx      <= 1'b0;
            r_hist    <= {r_hist[1:0], 1'b0};
            r_active  <= 1'b0;
            r_gap_cnt <= '0;
          end
          S_GAP: begin
            r_tx <= 1'b0;
            if (r_gap_cnt == GAP_LAST) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_gap_cnt <= w_gap_inc;
              r_done    <= (w_gap_inc == GAP_LAST);
            end
          end
          default: begin
            // Idle (or a start that was not taken): the line stays at 0.
            r_tx <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready  = r_ready;
  assign tx     = r_tx;
  assign active = r_active;
  assign done   = r_done;

endmodule
